// File: rtl/monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : monitor_pkg
//  Purpose  : Shared definitions for the checkpoint monitor: default data
//             width, run-state encoding and done-cause codes.
//  Revision : 1.0  initial release
// ============================================================================
package monitor_pkg;

    // Default width of num_inst, output_port and the table fields.
    localparam int c_word_size = 16;

    // Run state of the monitor.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Reason the run ended, reported on done_cause.
    localparam logic [1:0] c_cause_all_checked = 2'd0;
    localparam logic [1:0] c_cause_halt        = 2'd1;
    localparam logic [1:0] c_cause_timeout     = 2'd2;
    localparam logic [1:0] c_cause_fail_stop   = 2'd3;

endpackage : monitor_pkg
`default_nettype wire

// File: rtl/checkpoint_table.sv
`default_nettype none
// ============================================================================
//  Module   : checkpoint_table
//  Purpose  : NUM_TEST-entry register file of checkpoints
//             (instruction count, expected value, compare mask).
//             One synchronous write port, one asynchronous read port,
//             asynchronous clear of every entry.
//  Ports    : clk, reset_n        - clock, async active-low clear
//             wr_en/wr_idx/wr_*   - write strobe, index and entry data
//             rd_idx              - read pointer (one bit wider than an index
//                                   so it can reach NUM_TEST)
//             rd_valid            - rd_idx addresses a real entry
//             rd_inst/ans/mask    - entry at rd_idx (zero when not valid)
//  Revision : 1.0  initial release
// ============================================================================
module checkpoint_table #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_TEST  = 64,
    parameter int IDX_W     = $clog2(NUM_TEST)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [WORD_SIZE-1:0] wr_inst,
    input  logic [WORD_SIZE-1:0] wr_ans,
    input  logic [WORD_SIZE-1:0] wr_mask,
    input  logic [IDX_W:0]       rd_idx,
    output logic                 rd_valid,
    output logic [WORD_SIZE-1:0] rd_inst,
    output logic [WORD_SIZE-1:0] rd_ans,
    output logic [WORD_SIZE-1:0] rd_mask
);

    localparam int PTR_W = IDX_W + 1;

    logic [WORD_SIZE-1:0] r_inst [NUM_TEST];
    logic [WORD_SIZE-1:0] r_ans  [NUM_TEST];
    logic [WORD_SIZE-1:0] r_mask [NUM_TEST];

    // Write indices at or above NUM_TEST (non power-of-two sizes) match no
    // entry and are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_TEST; i++) begin
                r_inst[i] <= '0;
                r_ans[i]  <= '0;
                r_mask[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_TEST; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    r_inst[i] <= wr_inst;
                    r_ans[i]  <= wr_ans;
                    r_mask[i] <= wr_mask;
                end
            end
        end
    end

    // Compare-based read mux: the pointer legitimately reaches NUM_TEST at
    // the end of a run, so it must never be used as a raw array index.
    always_comb begin
        rd_valid = (rd_idx < PTR_W'(NUM_TEST));
        rd_inst  = '0;
        rd_ans   = '0;
        rd_mask  = '0;
        for (int i = 0; i < NUM_TEST; i++) begin
            if (rd_idx == PTR_W'(i)) begin
                rd_inst = r_inst[i];
                rd_ans  = r_ans[i];
                rd_mask = r_mask[i];
            end
        end
    end

endmodule : checkpoint_table
`default_nettype wire

// File: rtl/checkpoint_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : checkpoint_monitor
//  Purpose  : Watches CPU debug outputs (num_inst, output_port, is_halted)
//             against a loadable checkpoint table. Counts passed, failed and
//             missed checkpoints and ends the run on first failure
//             (optional), table exhaustion, CPU halt or cycle timeout.
//  Ports    : clk, reset_n             - clock, async active-low reset
//             ld_en/ld_idx/ld_*        - table load port (IDLE only)
//             start                    - one-cycle pulse, IDLE -> RUN
//             num_inst/output_port/
//             is_halted                - CPU debug outputs being monitored
//             running/done/done_cause  - run status
//             pass_cnt/fail_cnt/
//             miss_cnt                 - checkpoint result counters
//             first_fail_idx/_val      - entry and value of first failure
//             any_fail/all_pass        - summary flags
//             num_clock                - cycles spent in RUN (saturating)
//  Revision : 1.0  initial release
// ============================================================================
module checkpoint_monitor
    import monitor_pkg::*;
#(
    parameter int WORD_SIZE    = c_word_size,
    parameter int NUM_TEST     = 64,
    parameter int IDX_W        = $clog2(NUM_TEST),
    parameter int CYC_W        = 32,
    parameter int MAX_CYCLES   = 10000,
    parameter int STOP_ON_FAIL = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ld_en,
    input  logic [IDX_W-1:0]     ld_idx,
    input  logic [WORD_SIZE-1:0] ld_inst,
    input  logic [WORD_SIZE-1:0] ld_ans,
    input  logic [WORD_SIZE-1:0] ld_mask,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] num_inst,
    input  logic [WORD_SIZE-1:0] output_port,
    input  logic                 is_halted,
    output logic                 running,
    output logic                 done,
    output logic [1:0]           done_cause,
    output logic [IDX_W:0]       pass_cnt,
    output logic [IDX_W:0]       fail_cnt,
    output logic [IDX_W:0]       miss_cnt,
    output logic [IDX_W-1:0]     first_fail_idx,
    output logic [WORD_SIZE-1:0] first_fail_val,
    output logic                 any_fail,
    output logic                 all_pass,
    output logic [CYC_W-1:0]     num_clock
);

    localparam int               PTR_W        = IDX_W + 1;
    localparam logic [PTR_W-1:0] c_num_test   = PTR_W'(NUM_TEST);
    localparam logic [PTR_W-1:0] c_one_ptr    = PTR_W'(1);
    localparam logic [CYC_W:0]   c_max_cycles = (CYC_W + 1)'(MAX_CYCLES);
    localparam bit               c_timeout_en = (MAX_CYCLES != 0);
    localparam bit               c_stop_fail  = (STOP_ON_FAIL != 0);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_next;
    logic [1:0]           r_done_cause;
    logic [1:0]           w_cause_next;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     r_pass_cnt;
    logic [PTR_W-1:0]     r_fail_cnt;
    logic [PTR_W-1:0]     r_miss_cnt;
    logic [IDX_W-1:0]     r_first_fail_idx;
    logic [WORD_SIZE-1:0] r_first_fail_val;
    logic [CYC_W-1:0]     r_num_clock;

    // ------------------------------------------------------------------
    // Checkpoint table
    // ------------------------------------------------------------------
    logic                 w_tbl_wr;
    logic                 w_entry_valid;
    logic [WORD_SIZE-1:0] w_entry_inst;
    logic [WORD_SIZE-1:0] w_entry_ans;
    logic [WORD_SIZE-1:0] w_entry_mask;

    // The table is frozen outside IDLE so a run always checks what was loaded.
    assign w_tbl_wr = ld_en && (r_state == ST_IDLE);

    checkpoint_table #(
        .WORD_SIZE (WORD_SIZE),
        .NUM_TEST  (NUM_TEST),
        .IDX_W     (IDX_W)
    ) u_table (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (w_tbl_wr),
        .wr_idx   (ld_idx),
        .wr_inst  (ld_inst),
        .wr_ans   (ld_ans),
        .wr_mask  (ld_mask),
        .rd_idx   (r_ptr),
        .rd_valid (w_entry_valid),
        .rd_inst  (w_entry_inst),
        .rd_ans   (w_entry_ans),
        .rd_mask  (w_entry_mask)
    );

    // ------------------------------------------------------------------
    // Per-cycle evaluation of the entry under the pointer
    // ------------------------------------------------------------------
    logic             w_hit;
    logic             w_match;
    logic             w_pass;
    logic             w_fail;
    logic             w_miss;
    logic [PTR_W-1:0] w_ptr_next;
    logic [CYC_W:0]   w_clk_plus1;

    assign w_hit       = w_entry_valid && (num_inst == w_entry_inst);
    assign w_match     = (((output_port ^ w_entry_ans) & w_entry_mask) == '0);
    assign w_pass      = w_hit && w_match;
    assign w_fail      = w_hit && !w_match;
    // The CPU jumped past this checkpoint without ever sitting on it.
    assign w_miss      = w_entry_valid && (num_inst > w_entry_inst);
    assign w_ptr_next  = (w_hit || w_miss) ? (r_ptr + c_one_ptr) : r_ptr;
    // One bit wider so the timeout compare is exact even at saturation.
    assign w_clk_plus1 = {1'b0, r_num_clock} + (CYC_W + 1)'(1);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_done_cause <= c_cause_all_checked;
        end else begin
            r_state      <= w_state_next;
            r_done_cause <= w_cause_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. End conditions are judged on the result of this
    // cycle's compare, in priority order.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cause_next = r_done_cause;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (c_stop_fail && w_fail) begin
                    w_state_next = ST_DONE;
                    w_cause_next = c_cause_fail_stop;
                end else if (w_ptr_next == c_num_test) begin
                    w_state_next = ST_DONE;
                    w_cause_next = c_cause_all_checked;
                end else if (is_halted) begin
                    w_state_next = ST_DONE;
                    w_cause_next = c_cause_halt;
                end else if (c_timeout_en && (w_clk_plus1 == c_max_cycles)) begin
                    w_state_next = ST_DONE;
                    w_cause_next = c_cause_timeout;
                end
            end
            ST_DONE: begin
                w_state_next = ST_DONE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pointer, counters and first-failure capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr            <= '0;
            r_pass_cnt       <= '0;
            r_fail_cnt       <= '0;
            r_miss_cnt       <= '0;
            r_first_fail_idx <= '0;
            r_first_fail_val <= '0;
            r_num_clock      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_ptr            <= '0;
                        r_pass_cnt       <= '0;
                        r_fail_cnt       <= '0;
                        r_miss_cnt       <= '0;
                        r_first_fail_idx <= '0;
                        r_first_fail_val <= '0;
                        r_num_clock      <= '0;
                    end
                end
                ST_RUN: begin
                    if (!(&r_num_clock)) begin
                        r_num_clock <= r_num_clock + CYC_W'(1);
                    end
                    r_ptr <= w_ptr_next;
                    if (w_pass) begin
                        r_pass_cnt <= r_pass_cnt + c_one_ptr;
                    end
                    if (w_fail) begin
                        r_fail_cnt <= r_fail_cnt + c_one_ptr;
                        if (r_fail_cnt == '0) begin
                            r_first_fail_idx <= r_ptr[IDX_W-1:0];
                            r_first_fail_val <= output_port;
                        end
                    end
                    if (w_miss) begin
                        r_miss_cnt <= r_miss_cnt + c_one_ptr;
                    end
                end
                default: begin
                    // DONE: everything frozen until reset.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign running        = (r_state == ST_RUN);
    assign done           = (r_state == ST_DONE);
    assign done_cause     = r_done_cause;
    assign pass_cnt       = r_pass_cnt;
    assign fail_cnt       = r_fail_cnt;
    assign miss_cnt       = r_miss_cnt;
    assign first_fail_idx = r_first_fail_idx;
    assign first_fail_val = r_first_fail_val;
    assign any_fail       = (r_fail_cnt != '0);
    assign all_pass       = (r_state == ST_DONE) && (r_pass_cnt == c_num_test);
    assign num_clock      = r_num_clock;

endmodule : checkpoint_monitor
`default_nettype wire

// File: tb/tb_checkpoint_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_checkpoint_monitor
//  Purpose  : Self-checking bench for checkpoint_monitor. Each directed run
//             queues its hand-computed end-of-run result; a separate monitor
//             compares it when done rises.
//  Revision : 1.0  initial release
// ============================================================================
module tb_checkpoint_monitor;

    localparam int WORD_SIZE    = 16;
    localparam int NUM_TEST     = 3;
    localparam int IDX_W        = 2;
    localparam int CYC_W        = 32;
    localparam int MAX_CYCLES   = 20;
    localparam int STOP_ON_FAIL = 1;

    logic                 clk;
    logic                 reset_n;
    logic                 ld_en;
    logic [IDX_W-1:0]     ld_idx;
    logic [WORD_SIZE-1:0] ld_inst;
    logic [WORD_SIZE-1:0] ld_ans;
    logic [WORD_SIZE-1:0] ld_mask;
    logic                 start;
    logic [WORD_SIZE-1:0] num_inst;
    logic [WORD_SIZE-1:0] output_port;
    logic                 is_halted;
    logic                 running;
    logic                 done;
    logic [1:0]           done_cause;
    logic [IDX_W:0]       pass_cnt;
    logic [IDX_W:0]       fail_cnt;
    logic [IDX_W:0]       miss_cnt;
    logic [IDX_W-1:0]     first_fail_idx;
    logic [WORD_SIZE-1:0] first_fail_val;
    logic                 any_fail;
    logic                 all_pass;
    logic [CYC_W-1:0]     num_clock;

    checkpoint_monitor #(
        .WORD_SIZE    (WORD_SIZE),
        .NUM_TEST     (NUM_TEST),
        .IDX_W        (IDX_W),
        .CYC_W        (CYC_W),
        .MAX_CYCLES   (MAX_CYCLES),
        .STOP_ON_FAIL (STOP_ON_FAIL)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ld_en          (ld_en),
        .ld_idx         (ld_idx),
        .ld_inst        (ld_inst),
        .ld_ans         (ld_ans),
        .ld_mask        (ld_mask),
        .start          (start),
        .num_inst       (num_inst),
        .output_port    (output_port),
        .is_halted      (is_halted),
        .running        (running),
        .done           (done),
        .done_cause     (done_cause),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .miss_cnt       (miss_cnt),
        .first_fail_idx (first_fail_idx),
        .first_fail_val (first_fail_val),
        .any_fail       (any_fail),
        .all_pass       (all_pass),
        .num_clock      (num_clock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0]  cause;
        logic [31:0] pass;
        logic [31:0] fail;
        logic [31:0] miss;
        logic [31:0] ffi;
        logic [15:0] ffv;
        logic [31:0] nclk;
        logic        allp;
        logic        anyf;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [1:0] cause, input int pass, input int fail,
                            input int miss, input int ffi, input logic [15:0] ffv,
                            input int nclk);
        exp_t e;
        e.cause = cause;
        e.pass  = pass;
        e.fail  = fail;
        e.miss  = miss;
        e.ffi   = ffi;
        e.ffv   = ffv;
        e.nclk  = nclk;
        e.allp  = (pass == NUM_TEST);
        e.anyf  = (fail != 0);
        sb.push_back(e);
    endtask

    // Monitor: compares the queued result when done rises.
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_done = 1'b0;
            end else begin
                if (done && !prev_done) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got=done expected=no_done (t=%0t)", $time);
                    end else begin
                        e = sb.pop_front();
                        chk("done_cause",     32'(done_cause),     32'(e.cause));
                        chk("pass_cnt",       32'(pass_cnt),       e.pass);
                        chk("fail_cnt",       32'(fail_cnt),       e.fail);
                        chk("miss_cnt",       32'(miss_cnt),       e.miss);
                        chk("first_fail_idx", 32'(first_fail_idx), e.ffi);
                        chk("first_fail_val", 32'(first_fail_val), 32'(e.ffv));
                        chk("num_clock",      num_clock,           e.nclk);
                        chk("all_pass",       32'(all_pass),       32'(e.allp));
                        chk("any_fail",       32'(any_fail),       32'(e.anyf));
                        chk("running_at_done",32'(running),        32'd0);
                    end
                end
                prev_done = done;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_running"},   32'(running),        32'd0);
        chk({tag, "_done"},      32'(done),           32'd0);
        chk({tag, "_cause"},     32'(done_cause),     32'd0);
        chk({tag, "_pass"},      32'(pass_cnt),       32'd0);
        chk({tag, "_fail"},      32'(fail_cnt),       32'd0);
        chk({tag, "_miss"},      32'(miss_cnt),       32'd0);
        chk({tag, "_ffi"},       32'(first_fail_idx), 32'd0);
        chk({tag, "_ffv"},       32'(first_fail_val), 32'd0);
        chk({tag, "_any_fail"},  32'(any_fail),       32'd0);
        chk({tag, "_all_pass"},  32'(all_pass),       32'd0);
        chk({tag, "_num_clock"}, num_clock,           32'd0);
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        ld_en       = 1'b0;
        ld_idx      = '0;
        ld_inst     = '0;
        ld_ans      = '0;
        ld_mask     = '0;
        start       = 1'b0;
        num_inst    = '0;
        output_port = '0;
        is_halted   = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic load(input int idx, input logic [15:0] inst, input logic [15:0] ans,
                        input logic [15:0] mask, input bit with_start);
        ld_en   = 1'b1;
        ld_idx  = 2'(idx);
        ld_inst = inst;
        ld_ans  = ans;
        ld_mask = mask;
        start   = with_start;
        @(negedge clk);
        ld_en   = 1'b0;
        start   = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic step(input logic [15:0] ni, input logic [15:0] op);
        num_inst    = ni;
        output_port = op;
        @(negedge clk);
    endtask

    task automatic wait_done(input string name, input int limit);
        for (int i = 0; i < limit && !done; i++) @(negedge clk);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_wait_done: got=not_done expected=done within %0d cycles", name, limit);
        end
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        do_reset();
        check_all_zero("reset");

        // 1: three matching checkpoints; last load shares the edge with start;
        //    a load attempt during RUN must be ignored.
        push_exp(2'd0, 3, 0, 0, 0, 16'h0000, 8);
        load(0, 16'd3, 16'h0000, 16'hFFFF, 1'b0);
        load(1, 16'd5, 16'h0001, 16'hFFFF, 1'b0);
        load(2, 16'd7, 16'h0002, 16'hFFFF, 1'b1);
        chk("running_after_start", 32'(running), 32'd1);
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                ld_en = 1'b1; ld_idx = 2'd2; ld_inst = 16'd7; ld_ans = 16'hBEEF; ld_mask = 16'hFFFF;
            end
            step(16'(k), (k == 5) ? 16'h0001 : (k == 7) ? 16'h0002 : 16'h0000);
            ld_en = 1'b0;
        end
        wait_done("all_pass", 10);

        // 2: wrong value at checkpoint 1 stops the run.
        do_reset();
        push_exp(2'd3, 1, 1, 0, 1, 16'h0003, 6);
        load(0, 16'd3, 16'h0000, 16'hFFFF, 1'b0);
        load(1, 16'd5, 16'h0001, 16'hFFFF, 1'b0);
        load(2, 16'd7, 16'h0002, 16'hFFFF, 1'b0);
        start_run();
        for (int k = 0; k < 6; k++) step(16'(k), (k == 5) ? 16'h0003 : 16'h0000);
        wait_done("fail_stop", 10);

        // 3: masked compare passes despite differing upper byte; mask 0 always passes.
        do_reset();
        push_exp(2'd0, 3, 0, 0, 0, 16'h0000, 7);
        load(0, 16'd4, 16'hFFFE, 16'h00FF, 1'b0);
        load(1, 16'd5, 16'h0000, 16'h0000, 1'b0);
        load(2, 16'd6, 16'h1234, 16'hFFFF, 1'b0);
        start_run();
        for (int k = 0; k < 7; k++)
            step(16'(k), (k == 4) ? 16'h12FE : (k == 5) ? 16'hABCD : (k == 6) ? 16'h1234 : 16'h0000);
        wait_done("mask_pass", 10);

        // 3b: masked compare fails on a lower-byte difference.
        do_reset();
        push_exp(2'd3, 0, 1, 0, 0, 16'h00FD, 5);
        load(0, 16'd4, 16'hFFFE, 16'h00FF, 1'b0);
        load(1, 16'd5, 16'h0000, 16'h0000, 1'b0);
        load(2, 16'd6, 16'h0000, 16'h0000, 1'b0);
        start_run();
        for (int k = 0; k < 5; k++) step(16'(k), (k == 4) ? 16'h00FD : 16'h0000);
        wait_done("mask_fail", 10);

        // 4: num_inst jumps 2 -> 6: two misses on consecutive cycles, then entry 2 passes.
        do_reset();
        push_exp(2'd0, 1, 0, 2, 0, 16'h0000, 6);
        load(0, 16'd3, 16'h0000, 16'hFFFF, 1'b0);
        load(1, 16'd5, 16'h0000, 16'hFFFF, 1'b0);
        load(2, 16'd6, 16'h0007, 16'hFFFF, 1'b0);
        start_run();
        step(16'd0, 16'h0007);
        step(16'd1, 16'h0007);
        step(16'd2, 16'h0007);
        step(16'd6, 16'h0007);
        chk("miss_after_jump", 32'(miss_cnt), 32'd1);
        step(16'd6, 16'h0007);
        chk("miss_second", 32'(miss_cnt), 32'd2);
        step(16'd6, 16'h0007);
        wait_done("miss", 10);

        // 5: num_inst stuck at 0 -> timeout at 20 cycles.
        do_reset();
        push_exp(2'd2, 0, 0, 0, 0, 16'h0000, 20);
        load(0, 16'd100, 16'h0000, 16'hFFFF, 1'b0);
        load(1, 16'd100, 16'h0000, 16'hFFFF, 1'b0);
        load(2, 16'd100, 16'h0000, 16'hFFFF, 1'b0);
        start_run();
        wait_done("timeout", 40);

        // 6: halt on the same cycle as timeout wins.
        do_reset();
        push_exp(2'd1, 0, 0, 0, 0, 16'h0000, 20);
        load(0, 16'd100, 16'h0000, 16'hFFFF, 1'b0);
        load(1, 16'd100, 16'h0000, 16'hFFFF, 1'b0);
        load(2, 16'd100, 16'h0000, 16'hFFFF, 1'b0);
        start_run();
        for (int i = 0; i < 40 && num_clock != 32'd19; i++) @(negedge clk);
        is_halted = 1'b1;
        wait_done("halt_vs_timeout", 5);

        // 6b: halt on the first RUN cycle; that cycle's compare still counts.
        do_reset();
        push_exp(2'd1, 1, 0, 0, 0, 16'h0000, 1);
        load(0, 16'd0, 16'h0000, 16'hFFFF, 1'b0);
        load(1, 16'd5, 16'h0000, 16'hFFFF, 1'b0);
        load(2, 16'd6, 16'h0000, 16'hFFFF, 1'b0);
        is_halted = 1'b1;
        start_run();
        wait_done("halt_first", 5);

        // 7: failure on the last entry: FAIL_STOP outranks ALL_CHECKED.
        do_reset();
        push_exp(2'd3, 2, 1, 0, 2, 16'h0000, 4);
        load(0, 16'd1, 16'h0000, 16'hFFFF, 1'b0);
        load(1, 16'd2, 16'h0000, 16'hFFFF, 1'b0);
        load(2, 16'd3, 16'h0005, 16'hFFFF, 1'b0);
        start_run();
        for (int k = 0; k < 4; k++) step(16'(k), 16'h0000);
        wait_done("fail_last", 10);

        // 8: reset mid-run clears everything including the table.
        do_reset();
        load(0, 16'd1, 16'h0000, 16'hFFFF, 1'b0);
        load(1, 16'd2, 16'h0000, 16'hFFFF, 1'b0);
        load(2, 16'd9, 16'h0000, 16'hFFFF, 1'b0);
        start_run();
        for (int k = 0; k < 3; k++) step(16'(k), 16'h0000);
        chk("pass_before_reset", 32'(pass_cnt), 32'd2);
        chk("running_before_reset", 32'(running), 32'd1);
        #2 reset_n = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk);
        reset_n  = 1'b1;
        num_inst = '0;
        output_port = 16'h5555;
        @(negedge clk);
        push_exp(2'd0, 3, 0, 0, 0, 16'h0000, 3);
        start_run();
        wait_done("after_reset", 10);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_checkpoint_monitor
`default_nettype wire

// File: doc/checkpoint_monitor.md
Name: checkpoint_monitor

Overview:
Synthesizable, parametrised checkpoint checker for CPU self-test runs. It watches the CPU debug outputs num_inst, output_port and is_halted against a loadable table of (instruction count, expected value, compare mask) entries. It counts passes, fails and missed checkpoints, and stops on halt, timeout, table exhaustion or optional first failure. It sits beside the cpu on the debug ports, for use both on FPGA and under simulation.

Parameters:
WORD_SIZE, 16, width of num_inst, output_port and table fields
NUM_TEST, 64, number of checkpoint entries
IDX_W, $clog2(NUM_TEST), table index width
CYC_W, 32, cycle counter width
MAX_CYCLES, 10000, run cycle limit; 0 disables timeout
STOP_ON_FAIL, 1, 1 = end the run on the first failing compare

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
ld_en  in  1  table write strobe; honoured only in IDLE
ld_idx  in  IDX_W  table entry index
ld_inst  in  WORD_SIZE  checkpoint instruction count
ld_ans  in  WORD_SIZE  expected output_port
ld_mask  in  WORD_SIZE  compare mask; 1 = bit compared
start  in  1  one-cycle pulse, IDLE->RUN
num_inst  in  WORD_SIZE  CPU retired-instruction count
output_port  in  WORD_SIZE  CPU WWD output
is_halted  in  1  CPU halted
running  out  1  state==RUN
done  out  1  state==DONE
done_cause  out  2  0 ALL_CHECKED, 1 HALT, 2 TIMEOUT, 3 FAIL_STOP
pass_cnt  out  IDX_W+1  passed checkpoints
fail_cnt  out  IDX_W+1  failed checkpoints
miss_cnt  out  IDX_W+1  checkpoints skipped (num_inst jumped past)
first_fail_idx  out  IDX_W  index of first failing entry
first_fail_val  out  WORD_SIZE  output_port sampled at first failure
any_fail  out  1  fail_cnt!=0
all_pass  out  1  done && pass_cnt==NUM_TEST
num_clock  out  CYC_W  cycles spent in RUN

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs, counters and pointer ptr cleared to 0. Table entries cleared (inst=0, ans=0, mask=0). A run interrupted by reset must be reloaded.
- IDLE: ld_en writes the entry on the clk edge. start moves to RUN next cycle with ptr=0 and num_clock=0. ld_en and start asserted together: load happens, then the run starts.
- RUN, every cycle:
  - num_clock increments.
  - With e=table[ptr] and ptr<NUM_TEST:
    - num_inst==e.inst: compare ((output_port^e.ans)&e.mask)==0. On match pass_cnt++, otherwise fail_cnt++. first_fail_* are captured only on the first fail. ptr++.
    - num_inst>e.inst (unsigned): miss_cnt++, ptr++.
    - Otherwise: hold.
  - At most one entry is evaluated per cycle. Each entry is evaluated exactly once, on the first cycle num_inst equals it; later cycles at the same count are not rechecked.
  - Entries are required sorted ascending by inst. Duplicate inst values are evaluated on consecutive cycles.
  - ld_en and start are ignored.
- RUN->DONE, evaluated after the current cycle's compare is committed. Priority:
  1. FAIL_STOP: STOP_ON_FAIL and this cycle failed.
  2. ALL_CHECKED: ptr becomes NUM_TEST.
  3. HALT: is_halted.
  4. TIMEOUT: MAX_CYCLES!=0 and num_clock+1==MAX_CYCLES.
- DONE: all counters frozen; only reset exits. Entries not evaluated count as no-result (NUM_TEST-pass-fail-miss), which is not an output.
- Counters never overflow: IDX_W+1 bits hold NUM_TEST. num_clock saturates at all-ones.

Decomposition:
- Package monitor_pkg: WORD_SIZE default, state encoding (IDLE/RUN/DONE), done_cause constants.
- Sub-module checkpoint_table: NUM_TEST-entry register file with one sync write port (ld_*), async read at ptr, and async clear. The FSM, counters and compare logic stay in checkpoint_monitor.

Test Plan:
- Load 3 entries (3,0x0000,FFFF), (5,0x0001,FFFF), (7,0x0002,FFFF); drive num_inst 0..7 with matching output_port -> pass_cnt=3, done, done_cause=0, all_pass=1.
- Same table, output_port=0x0003 at num_inst=5, STOP_ON_FAIL=1 -> done the cycle after, done_cause=3, fail_cnt=1, first_fail_idx=1, first_fail_val=0x0003, pass_cnt=1.
- Entry (4,0xFFFE,0x00FF), output_port=0x12FE at num_inst=4 -> pass (masked upper byte).
- Table (3..),(5..); num_inst jumps 2->6 -> miss_cnt=1 at entry 0, then entry 1 missed next cycle, miss_cnt=2, ALL_CHECKED.
- MAX_CYCLES=20, num_inst stuck at 0 -> done at num_clock=20, done_cause=2; with is_halted raised at cycle 20 as well, done_cause=1.
- Assert reset_n=0 mid-RUN at pass_cnt=2 -> all outputs 0 immediately, state IDLE, table cleared; start without reload, num_inst=0 with entry 0 (inst=0, mask=0) -> pass.
